// File: rtl/fdd_pkg.sv
// Shared constants for the floppy controller register block: register offsets,
// CSR/status bit positions and the ID version nibble.
package fdd_pkg;

  localparam logic [1:0] REG_CSR   = 2'd0;
  localparam logic [1:0] REG_DATA  = 2'd1;
  localparam logic [1:0] REG_FSTAT = 2'd2;
  localparam logic [1:0] REG_ID    = 2'd3;

  // CSR write fields
  localparam int unsigned CSR_MOTOR     = 4;
  localparam int unsigned CSR_HEAD      = 5;
  localparam int unsigned CSR_DIR       = 6;
  localparam int unsigned CSR_STEP      = 7;
  localparam int unsigned CSR_FIND_SYNC = 8;
  localparam int unsigned CSR_WR_MODE   = 9;
  localparam int unsigned CSR_DRV_EN    = 10;
  localparam int unsigned CSR_IRQ_EN    = 11;

  // CSR read status fields
  localparam int unsigned ST_TR0    = 0;
  localparam int unsigned ST_RDY    = 1;
  localparam int unsigned ST_WPR    = 2;
  localparam int unsigned ST_TR     = 7;
  localparam int unsigned ST_IRQ_EN = 11;
  localparam int unsigned ST_UDR    = 12;
  localparam int unsigned ST_OVR    = 13;
  localparam int unsigned ST_CRC_OK = 14;
  localparam int unsigned ST_IND    = 15;

  // FSTAT write fields
  localparam int unsigned FST_FLUSH_RX  = 0;
  localparam int unsigned FST_FLUSH_TX  = 1;
  localparam int unsigned FST_CLR_FLAGS = 2;

  localparam logic [3:0] ID_VERSION = 4'h2;

endpackage

// File: rtl/fdd_ctrl_fifo_if.sv
// Wishbone slave bus bundle for the floppy controller register block.
interface fdd_ctrl_fifo_if;
  logic [16:0] adr;
  logic [15:0] dat_w;
  logic [15:0] dat_r;
  logic        cyc;
  logic        stb;
  logic        wre;
  logic        ack;

  modport master (output adr, dat_w, cyc, stb, wre, input dat_r, ack);
  modport slave  (input adr, dat_w, cyc, stb, wre, output dat_r, ack);
endinterface

// File: rtl/fdd_word_fifo.sv
// Synchronous word FIFO with flush; head word is visible on rdata while non-empty.
module fdd_word_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fdd_ctrl_fifo.sv
// Floppy controller register block with RX/TX word FIFOs on a Wishbone slave.
// Define FDD_IRQ_EN to add the irq output and the CSR irq_en bit.
module fdd_ctrl_fifo
  import fdd_pkg::*;
#(
  parameter int unsigned NUM_DRIVES  = 4,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] BASE_ADR    = 16'o177130,
  parameter int unsigned STEP_CYCLES = 8,
  localparam int unsigned DRV_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1,
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  ppu_vm_clk_p,
  input  logic                  ppu_vm_init_i,
  fdd_ctrl_fifo_if.slave        bus,
  input  logic [15:0]           data_in,
  input  logic                  valid,
  output logic [15:0]           data_out,
  output logic                  write,
  input  logic                  wr_req,
  output logic [DRV_W-1:0]      drive,
  output logic                  motor,
  output logic                  head,
  output logic                  dir,
  output logic                  step,
  input  logic                  sync,
  input  logic                  crc_ok,
  input  logic                  rdy,
  input  logic                  tr0,
  input  logic                  ind,
  input  logic [NUM_DRIVES-1:0] wrprt_dsk
`ifdef FDD_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int unsigned STEP_W     = $clog2(STEP_CYCLES + 1);
  localparam logic [3:0]  ID_DRIVES  = 4'(NUM_DRIVES);
  localparam logic [7:0]  ID_FLOG    = 8'($clog2(FIFO_DEPTH));

  logic              ack_q, write_q, motor_q, head_q, dir_q, wr_mode_q;
  logic              find_sync_q, ovr_q, udr_q, old_valid_q;
  logic [15:0]       dat_q, data_out_q, rd_data, csr_rd;
  logic [DRV_W-1:0]  drive_q;
  logic [STEP_W-1:0] step_cnt_q;

  logic [1:0] sel;
  logic       hit, req, wr_acc, rd_acc;
  logic       csr_wr, data_wr, data_rd, fstat_wr;
  logic       tr, drive_ok, wpr, rdy_m, ovr_set, udr_set, clr_flags;

  logic             rx_push, rx_flush, rx_full, rx_empty;
  logic             tx_pop, tx_flush, tx_full, tx_empty;
  logic [15:0]      rx_rdata, tx_rdata;
  logic [CNT_W-1:0] rx_count, tx_count;

  logic unused_adr;
  assign unused_adr = ^{bus.adr[16], bus.adr[0]};

  assign sel      = bus.adr[2:1];
  assign hit      = (bus.adr[15:3] == BASE_ADR[15:3]);
  assign req      = bus.cyc & bus.stb & hit & ~ack_q;
  assign wr_acc   = req & bus.wre;
  assign rd_acc   = req & ~bus.wre;
  assign csr_wr   = wr_acc & (sel == REG_CSR);
  assign data_wr  = wr_acc & (sel == REG_DATA);
  assign data_rd  = rd_acc & (sel == REG_DATA);
  assign fstat_wr = wr_acc & (sel == REG_FSTAT);

  assign rx_push   = valid & ~old_valid_q;
  assign rx_flush  = fstat_wr & bus.dat_w[FST_FLUSH_RX];
  assign tx_flush  = fstat_wr & bus.dat_w[FST_FLUSH_TX];
  assign clr_flags = fstat_wr & bus.dat_w[FST_CLR_FLAGS];
  assign tx_pop    = wr_req & ~tx_empty;

  // Dropped words: a full FIFO whose pop side does not free a slot this cycle
  assign ovr_set = (rx_push & rx_full & ~data_rd & ~rx_flush) | (data_wr & tx_full & ~tx_pop);
  assign udr_set = wr_req & tx_empty;

  fdd_word_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (ppu_vm_clk_p),
    .rst   (ppu_vm_init_i),
    .push  (rx_push),
    .wdata (data_in),
    .pop   (data_rd),
    .flush (rx_flush),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  fdd_word_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (ppu_vm_clk_p),
    .rst   (ppu_vm_init_i),
    .push  (data_wr),
    .wdata (bus.dat_w),
    .pop   (tx_pop),
    .flush (tx_flush),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign tr       = ~rx_empty | (wr_mode_q & ~tx_full);
  assign drive_ok = (32'(drive_q) < NUM_DRIVES);
  assign wpr      = drive_ok ? wrprt_dsk[drive_q] : 1'b1;
  assign rdy_m    = rdy & drive_ok;

`ifdef FDD_IRQ_EN
  logic irq_en_q, irq_q;
  assign irq = irq_q;

  always_ff @(posedge ppu_vm_clk_p) begin
    if (ppu_vm_init_i) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (csr_wr) irq_en_q <= bus.dat_w[CSR_IRQ_EN];
      irq_q <= irq_en_q & (tr | ovr_q | udr_q);
    end
  end
`endif

  always_comb begin
    csr_rd = '0;
    if (!find_sync_q) begin
      csr_rd[ST_IND]    = ind;
      csr_rd[ST_CRC_OK] = crc_ok;
      csr_rd[ST_OVR]    = ovr_q;
      csr_rd[ST_UDR]    = udr_q;
      csr_rd[ST_TR]     = tr;
      csr_rd[ST_WPR]    = wpr;
      csr_rd[ST_RDY]    = rdy_m;
      csr_rd[ST_TR0]    = tr0;
`ifdef FDD_IRQ_EN
      csr_rd[ST_IRQ_EN] = irq_en_q;
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (sel)
      REG_CSR:   rd_data = csr_rd;
      REG_DATA:  rd_data = rx_empty ? 16'h0000 : rx_rdata;
      REG_FSTAT: rd_data = {8'(rx_count), 8'(tx_count)};
      REG_ID:    rd_data = {ID_VERSION, ID_DRIVES, ID_FLOG};
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge ppu_vm_clk_p) begin
    if (ppu_vm_init_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      write_q     <= 1'b0;
      data_out_q  <= '0;
      drive_q     <= '0;
      motor_q     <= 1'b0;
      head_q      <= 1'b0;
      dir_q       <= 1'b0;
      wr_mode_q   <= 1'b0;
      find_sync_q <= 1'b0;
      ovr_q       <= 1'b0;
      udr_q       <= 1'b0;
      old_valid_q <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      ack_q       <= req;
      dat_q       <= rd_acc ? rd_data : 16'h0000;
      old_valid_q <= valid;
      write_q     <= tx_pop;
      if (tx_pop) data_out_q <= tx_rdata;

      // Sticky flags: a new event in the clearing cycle survives the clear
      ovr_q <= (ovr_q & ~clr_flags) | ovr_set;
      udr_q <= (udr_q & ~clr_flags) | udr_set;

      if (csr_wr) begin
        drive_q   <= bus.dat_w[CSR_DRV_EN] ? ~bus.dat_w[DRV_W-1:0] : '0;
        motor_q   <= bus.dat_w[CSR_MOTOR];
        head_q    <= bus.dat_w[CSR_HEAD];
        dir_q     <= bus.dat_w[CSR_DIR];
        wr_mode_q <= bus.dat_w[CSR_WR_MODE];
      end

      if (csr_wr && bus.dat_w[CSR_FIND_SYNC]) find_sync_q <= ~sync;
      else if (sync)                          find_sync_q <= 1'b0;

      // Step pulse is not retriggerable while the counter runs
      if (step_cnt_q != '0)                        step_cnt_q <= step_cnt_q - STEP_W'(1);
      else if (csr_wr && bus.dat_w[CSR_STEP])      step_cnt_q <= STEP_W'(STEP_CYCLES);
    end
  end

  assign bus.ack   = ack_q;
  assign bus.dat_r = dat_q;
  assign data_out  = data_out_q;
  assign write     = write_q;
  assign drive     = drive_q;
  assign motor     = motor_q;
  assign head      = head_q;
  assign dir       = dir_q;
  assign step      = (step_cnt_q != '0);

endmodule
